// File: rtl/ve_mult_seq.sv
// Sequential vertical-and-crosswise multiplier: one digit column per clock, valid/ready in and out.
// Define VE_MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module ve_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = 2 * DIGIT + $clog2(N);
  localparam int unsigned CW = $clog2(2 * N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(2 * N - 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_sum;
  logic [CW-1:0]    col;
  logic [SW-1:0]    col_sum;
  logic [DIGIT-1:0] b_sel;

`ifdef VE_MULT_SIGNED_EN
  logic sign_q;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Column sum: each a digit pairs with the single b digit that lands in column col
  always_comb begin
    col_sum = '0;
    b_sel   = '0;
    for (int i = 0; i < int'(N); i++) begin
      b_sel = '0;
      for (int j = 0; j < int'(N); j++) begin
        if (i + j == int'(col)) b_sel = b_q[j*DIGIT +: DIGIT];
      end
      col_sum = col_sum + SW'(a_q[i*DIGIT +: DIGIT]) * SW'(b_sel);
    end
  end

  assign acc_sum = acc + (PW'(col_sum) << (DIGIT * col));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      col       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef VE_MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a_mag;
            b_q      <= b_mag;
`ifdef VE_MULT_SIGNED_EN
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            acc      <= '0;
            col      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (col == LAST_COL) begin
`ifdef VE_MULT_SIGNED_EN
            p <= sign_q ? -acc_sum : acc_sum;
`else
            p <= acc_sum;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            col <= col + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ve_mult_seq.sv
// Directed and swept checks for ve_mult_seq at 32/8, 16/4 and 24/8.
module tb_ve_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] p;

  logic        iv_s, or_s;
  logic [15:0] a16, b16;
  logic [23:0] a24, b24;
  logic        ir16, ov16, busy16, ir24, ov24, busy24;
  logic [31:0] p16;
  logic [47:0] p24;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef VE_MULT_SIGNED_EN
  localparam logic [63:0] EXP_FF_FF = 64'h0000000000000001;
  localparam logic [63:0] EXP_FF_2  = 64'hFFFFFFFFFFFFFFFE;
`else
  localparam logic [63:0] EXP_FF_FF = 64'hFFFFFFFE00000001;
  localparam logic [63:0] EXP_FF_2  = 64'h00000001FFFFFFFE;
`endif

  ve_mult_seq #(.WIDTH(32), .DIGIT(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  ve_mult_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or_s), .p(p16), .busy(busy16)
  );

  ve_mult_seq #(.WIDTH(24), .DIGIT(8)) u_dut24 (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir24), .a(a24), .b(b24),
    .out_valid(ov24), .out_ready(or_s), .p(p24), .busy(busy24)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the acceptance edge until out_valid is seen (0 if never within the bound)
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (out_valid) lat = k;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [63:0] exp);
    int c;
    int lat;
    c = 0;
    while (!in_ready && c < 20) begin
      tick();
      c++;
    end
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd7);
    check({tag, "_p"}, p, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int          lat, l16, l24, seen;
    longint      r1, r2;
    logic [31:0] ra, rb, e16;
    logic [47:0] e24;

    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    iv_s = 1'b0; or_s = 1'b0; a16 = '0; b16 = '0; a24 = '0; b24 = '0;

    repeat (3) tick();
    check("rst_p", p, 64'd0);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ir", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_ir", 64'(in_ready), 64'd1);

    do_op("u3x5", 32'd3, 32'd5, 64'h000000000000000F);
    do_op("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, EXP_FF_FF);
    do_op("b16", 32'h00010000, 32'h00010000, 64'h0000000100000000);
    do_op("ffx2", 32'hFFFFFFFF, 32'd2, EXP_FF_2);
    do_op("minxmin", 32'h80000000, 32'h80000000, 64'h4000000000000000);

    // Backpressure with a competing operand pair held on the input
    a = 32'd6; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    check("bp_lat", 64'(lat), 64'd7);
    a = 32'd2; b = 32'd2; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_p", p, 64'd42);
      check("bp_ov", 64'(out_valid), 64'd1);
      check("bp_ir", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_busy", 64'(busy), 64'd0);
    check("bp_rel_ir", 64'(in_ready), 64'd1);
    check("bp_rel_ov", 64'(out_valid), 64'd0);
    check("bp_p_hold", p, 64'd42);
    tick();
    in_valid = 1'b0;
    check("bp_accept", 64'(busy), 64'd1);
    wait_done(lat);
    check("bp2_lat", 64'(lat), 64'd7);
    check("bp2_p", p, 64'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the third CALC cycle
    a = 32'd11; b = 32'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    tick();
    tick();
    check("mid_ov", 64'(out_valid), 64'd0);
    check("mid_p", p, 64'd0);
    check("mid_ir", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("mid_no_pulse", 64'(seen), 64'd0);
    do_op("u7x9", 32'd7, 32'd9, 64'd63);

    // Parameter sweep on the narrow instances
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) begin ra = 32'hFFFFFFFF; rb = 32'hFFFFFFFF; end
      if (i == 1) begin ra = 32'h00808000; rb = 32'h00808000; end
      if (i == 2) begin ra = 32'h0; rb = 32'hFFFFFFFF; end
      a16 = ra[15:0]; b16 = rb[15:0];
      a24 = ra[23:0]; b24 = rb[23:0];
`ifdef VE_MULT_SIGNED_EN
      r1 = $signed(a16); r2 = $signed(b16);
      e16 = 32'(r1 * r2);
      r1 = $signed(a24); r2 = $signed(b24);
      e24 = 48'(r1 * r2);
`else
      r1 = a16; r2 = b16;
      e16 = 32'(r1 * r2);
      r1 = a24; r2 = b24;
      e24 = 48'(r1 * r2);
`endif
      iv_s = 1'b1;
      tick();
      iv_s = 1'b0;
      l16 = 0;
      l24 = 0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (ov16 && l16 == 0) l16 = k;
        if (ov24 && l24 == 0) l24 = k;
      end
      check("sw16_lat", 64'(l16), 64'd7);
      check("sw24_lat", 64'(l24), 64'd5);
      check("sw16_p", 64'(p16), 64'(e16));
      check("sw24_p", 64'(p24), 64'(e24));
      or_s = 1'b1;
      tick();
      or_s = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
